// File: rtl/axi4_writer_pkg.sv
// ============================================================
// Package : axi4_writer_pkg
// Shared state encoding and AXI4 constants for the frame writer.
// Rev     : 1.0
// ============================================================
`default_nettype none

package axi4_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } axiw_state_t;

  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [3:0] CACHE_BUFFERABLE = 4'b0011;

endpackage

`default_nettype wire

// File: rtl/axiw_sync_fifo.sv
// ============================================================
// Module : axiw_sync_fifo
// Single-clock first-word-fall-through FIFO with occupancy count.
// Rev    : 1.0
// ============================================================
`default_nettype none

module axiw_sync_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_wr_en,
  input  logic [DATA_W-1:0]           i_wr_data,
  input  logic                        i_rd_en,
  output logic [DATA_W-1:0]           o_rd_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int c_aw = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_full    = (r_count == (c_aw+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr      = i_wr_en & ~o_full;
  assign w_rd      = i_rd_en & ~o_empty;

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi4_frame_writer.sv
// ============================================================
// Module : axi4_frame_writer
// Pixel stream to AXI4 INCR-burst frame writer over an N-buffer ring.
// Optional macro AXIW_PERF_CNT_EN adds burst/stall performance counters.
// Rev    : 1.0
// ============================================================
`default_nettype none

module axi4_frame_writer
  import axi4_writer_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_BEATS = 19200,
  parameter int NUM_BUFS    = 3,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic                clk_100Mhz,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [ADDR_W-1:0]   cfg_stride,
  input  logic                cfg_enable,
  input  logic                err_clr,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic                frame_done,
  output logic [1:0]          frame_buf_idx,
  output logic                wr_error,
  output logic                len_error,
  output logic                busy
`ifdef AXIW_PERF_CNT_EN
  ,
  output logic [31:0]         perf_bursts,
  output logic [31:0]         perf_stall
`endif
);

  localparam int c_size  = $clog2(DATA_W/8);
  localparam int c_cnt_w = $clog2(FRAME_BEATS + BURST_LEN + 1);
  localparam int c_fc_w  = $clog2(FIFO_DEPTH) + 1;

  axiw_state_t        r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_in_cnt, r_frame_cnt, w_remain, w_cur_len;
  logic [7:0]         r_beat, r_awlen;
  logic [ADDR_W-1:0]  r_awaddr, r_buf_base, w_base;
  logic [1:0]         r_idx, r_buf_idx;
  logic [DATA_W-1:0]  w_fifo_dout;
  logic [c_fc_w-1:0]  w_fifo_count;
  logic               w_fifo_full, w_fifo_empty;
  logic               r_en_hold, w_en_eff, w_accept, w_last_in;
  logic               r_done, r_wr_err, r_len_err;
  logic               w_start, w_w_hs, w_b_hs, w_pop, w_burst_last, w_frame_end;

  // Enable only takes effect between frames so a frame is never truncated.
  assign w_en_eff  = (r_in_cnt == '0) ? cfg_enable : r_en_hold;
  assign s_tready  = w_en_eff & ~w_fifo_full;
  assign w_accept  = s_tvalid & s_tready;
  assign w_last_in = (r_in_cnt == c_cnt_w'(FRAME_BEATS - 1));

  assign w_remain    = c_cnt_w'(FRAME_BEATS) - r_frame_cnt;
  assign w_cur_len   = (w_remain > c_cnt_w'(BURST_LEN)) ? c_cnt_w'(BURST_LEN) : w_remain;
  assign w_base      = (r_frame_cnt == '0) ? cfg_base_addr + ADDR_W'(r_idx) * cfg_stride
                                           : r_buf_base;
  assign w_frame_end = ((r_frame_cnt + w_cur_len) == c_cnt_w'(FRAME_BEATS));

  assign AWVALID      = (r_state == ST_ADDR);
  assign WVALID       = (r_state == ST_DATA);
  assign w_burst_last = (r_beat == r_awlen);
  assign WLAST        = WVALID & w_burst_last;
  assign w_w_hs       = WVALID & WREADY;
  assign w_pop        = w_w_hs & ~w_fifo_empty;
  assign w_b_hs       = (r_state == ST_RESP) & BVALID;

  assign AWADDR        = r_awaddr;
  assign AWLEN         = r_awlen;
  assign AWSIZE        = 3'(c_size);
  assign AWBURST       = BURST_INCR;
  assign AWCACHE       = CACHE_BUFFERABLE;
  assign AWPROT        = 3'b000;
  assign WDATA         = w_fifo_dout;
  assign WSTRB         = '1;
  assign BREADY        = 1'b1;
  assign busy          = (r_state != ST_IDLE);
  assign frame_done    = r_done;
  assign frame_buf_idx = r_buf_idx;
  assign wr_error      = r_wr_err;
  assign len_error     = r_len_err;

  axiw_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_100Mhz),
    .rst       (rst),
    .i_wr_en   (w_accept),
    .i_wr_data (s_tdata),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_dout),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A burst only starts once it is fully buffered, so WVALID never gaps.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: if (32'(w_fifo_count) >= 32'(w_cur_len)) begin
        w_state_nxt = ST_ADDR;
        w_start     = 1'b1;
      end
      ST_ADDR: if (AWREADY) w_state_nxt = ST_DATA;
      ST_DATA: if (WREADY && w_burst_last) w_state_nxt = ST_RESP;
      ST_RESP: if (BVALID) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      r_in_cnt  <= '0;
      r_en_hold <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      if (r_in_cnt == '0) r_en_hold <= cfg_enable;
      if (w_accept) r_in_cnt <= w_last_in ? '0 : r_in_cnt + 1'b1;
      if (err_clr)                             r_len_err <= 1'b0;
      else if (w_accept && (s_tlast != w_last_in)) r_len_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_buf_base  <= '0;
      r_beat      <= '0;
      r_frame_cnt <= '0;
      r_idx       <= '0;
      r_buf_idx   <= '0;
      r_done      <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_awaddr   <= w_base + (ADDR_W'(r_frame_cnt) << c_size);
        r_awlen    <= 8'(w_cur_len - 1'b1);
        r_buf_base <= w_base;
        r_beat     <= '0;
      end
      if (w_w_hs) r_beat <= r_beat + 8'd1;
      if (w_b_hs) begin
        if (w_frame_end) begin
          r_frame_cnt <= '0;
          r_done      <= 1'b1;
          r_buf_idx   <= r_idx;
          r_idx       <= (r_idx == 2'(NUM_BUFS - 1)) ? 2'd0 : r_idx + 2'd1;
        end else begin
          r_frame_cnt <= r_frame_cnt + w_cur_len;
        end
      end
      if (err_clr)                              r_wr_err <= 1'b0;
      else if (w_b_hs && (BRESP != RESP_OKAY)) r_wr_err <= 1'b1;
    end
  end

`ifdef AXIW_PERF_CNT_EN
  logic [31:0] r_perf_bursts, r_perf_stall;

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      r_perf_bursts <= '0;
      r_perf_stall  <= '0;
    end else if (err_clr) begin
      r_perf_bursts <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_b_hs && (r_perf_bursts != '1)) r_perf_bursts <= r_perf_bursts + 32'd1;
      if (s_tvalid && !s_tready && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_bursts = r_perf_bursts;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi4_frame_writer.sv
// ============================================================
// Module : tb_axi4_frame_writer
// Directed self-checking bench for axi4_frame_writer (100-beat frames).
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_axi4_frame_writer;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 64;
  localparam int BURST_LEN   = 64;
  localparam int FRAME_BEATS = 100;
  localparam int NUM_BUFS    = 3;
  localparam int FIFO_DEPTH  = 128;

  logic              clk_100Mhz = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid, s_tready, s_tlast;
  logic [ADDR_W-1:0] cfg_base_addr, cfg_stride;
  logic              cfg_enable, err_clr;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID, AWREADY;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE, AWPROT;
  logic [1:0]        AWBURST, BRESP;
  logic [3:0]        AWCACHE;
  logic [DATA_W-1:0] WDATA;
  logic [7:0]        WSTRB;
  logic              WLAST, WVALID, WREADY, BVALID, BREADY;
  logic              frame_done, wr_error, len_error, busy;
  logic [1:0]        frame_buf_idx;
`ifdef AXIW_PERF_CNT_EN
  logic [31:0]       perf_bursts, perf_stall;
`endif

  axi4_frame_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .FRAME_BEATS(FRAME_BEATS), .NUM_BUFS(NUM_BUFS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_100Mhz(clk_100Mhz), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride),
    .cfg_enable(cfg_enable), .err_clr(err_clr),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .frame_done(frame_done), .frame_buf_idx(frame_buf_idx),
    .wr_error(wr_error), .len_error(len_error), .busy(busy)
`ifdef AXIW_PERF_CNT_EN
    , .perf_bursts(perf_bursts), .perf_stall(perf_stall)
`endif
  );

  initial forever #5 clk_100Mhz = ~clk_100Mhz;

  int total = 0;
  int bad   = 0;

  // stream source state
  int s_idx = 0, s_limit = 0, s_origin = 0, lerr_idx = -1;
  // AXI slave model state
  int aw_delay = 0, aw_wait = 0, wbeat = 0, nb = 0, err_burst = 5;
  int exp_w = 0, stab_viol = 0, wv_viol = 0, excl_viol = 0;
  bit w_toggle = 0, in_data = 0, b_pend = 0;
  logic [7:0]        cur_len_m, hold_len;
  logic [ADDR_W-1:0] hold_addr;
  logic [ADDR_W-1:0] aw_addr_q[$];
  logic [7:0]        aw_len_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_aw(input string tag, input int idx, input logic [31:0] addr, input logic [7:0] len);
    if (idx < aw_addr_q.size()) begin
      chk({tag, "_awaddr"}, 64'(aw_addr_q[idx]), 64'(addr));
      chk({tag, "_awlen"}, 64'(aw_len_q[idx]), 64'(len));
    end else begin
      chk({tag, "_awcount"}, 64'(aw_addr_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk_100Mhz);
    while (frame_done !== 1'b1 && n < 4000) begin
      @(negedge clk_100Mhz);
      n++;
    end
    chk({tag, "_done"}, 64'(frame_done), 64'd1);
    @(negedge clk_100Mhz);
    chk({tag, "_pulse"}, 64'(frame_done), 64'd0);
  endtask

  initial begin : stream
    bit acc;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    forever begin
      @(negedge clk_100Mhz);
      acc = s_tvalid && s_tready && !rst;
      @(posedge clk_100Mhz);
      #1;
      if (acc) s_idx++;
      s_tvalid = (s_idx < s_limit) && !rst;
      s_tdata  = 64'(s_idx);
      s_tlast  = (((s_idx - s_origin) % FRAME_BEATS) == FRAME_BEATS - 1) || (s_idx == lerr_idx);
    end
  end

  initial begin : axi_slave
    bit aw_hs, w_hs, b_hs;
    AWREADY = 1'b0;
    WREADY  = 1'b1;
    BVALID  = 1'b0;
    BRESP   = 2'b00;
    forever begin
      @(negedge clk_100Mhz);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BVALID && BREADY;
      if (AWVALID && WVALID) excl_viol++;
      if (rst) begin
        in_data = 0; aw_wait = 0; b_pend = 0; wbeat = 0; b_hs = 0;
      end else begin
        if (in_data && !WVALID) wv_viol++;
        if (aw_hs) begin
          aw_addr_q.push_back(AWADDR);
          aw_len_q.push_back(AWLEN);
          cur_len_m = AWLEN;
          wbeat = 0; aw_wait = 0; in_data = 1;
        end else if (AWVALID) begin
          if (aw_wait > 0 && (AWADDR !== hold_addr || AWLEN !== hold_len)) stab_viol++;
          hold_addr = AWADDR;
          hold_len  = AWLEN;
          aw_wait++;
        end
        if (w_hs) begin
          chk("wdata", WDATA, 64'(exp_w));
          chk("wlast", 64'(WLAST), 64'(wbeat == int'(cur_len_m)));
          exp_w++;
          if (WLAST) begin
            in_data = 0;
            b_pend  = 1;
          end
          wbeat++;
        end
        if (b_hs) nb++;
      end
      @(posedge clk_100Mhz);
      #1;
      if (rst) begin
        BVALID = 1'b0;
      end else begin
        if (b_hs) BVALID = 1'b0;
        if (b_pend) begin
          BVALID = 1'b1;
          BRESP  = (nb == err_burst) ? 2'b10 : 2'b00;
          b_pend = 0;
        end
      end
      AWREADY = (aw_wait >= aw_delay);
      WREADY  = w_toggle ? !WREADY : 1'b1;
    end
  end

  initial begin : main
    int fb, n;
    rst = 1'b1;
    cfg_base_addr = 32'h1000_0000;
    cfg_stride    = 32'h0010_0000;
    cfg_enable    = 1'b1;
    err_clr       = 1'b0;
    repeat (3) @(posedge clk_100Mhz);
    @(negedge clk_100Mhz);
    chk("rst_awvalid", 64'(AWVALID), 64'd0);
    chk("rst_wvalid", 64'(WVALID), 64'd0);
    chk("rst_wlast", 64'(WLAST), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_errs", {62'd0, wr_error, len_error}, 64'd0);
    chk("rst_awaddr", 64'(AWADDR), 64'd0);
    chk("rst_bufidx", 64'(frame_buf_idx), 64'd0);
    chk("awsize", 64'(AWSIZE), 64'd3);
    chk("awburst", 64'(AWBURST), 64'd1);
    chk("awcache", 64'(AWCACHE), 64'd3);
    chk("awprot", 64'(AWPROT), 64'd0);
    chk("wstrb", 64'(WSTRB), 64'hff);
    chk("bready", 64'(BREADY), 64'd1);
    rst = 1'b0;

    // frame 0: full burst then 36-beat partial burst
    fb = aw_addr_q.size();
    s_limit = 100;
    wait_done("f0");
    chk_aw("f0_b0", fb, 32'h1000_0000, 8'd63);
    chk_aw("f0_b1", fb + 1, 32'h1000_0200, 8'd35);
    chk("f0_bufidx", 64'(frame_buf_idx), 64'd0);

    // frame 1: slow AWREADY and toggling WREADY
    aw_delay = 10;
    w_toggle = 1;
    fb = aw_addr_q.size();
    s_limit = 200;
    wait_done("f1");
    chk_aw("f1_b0", fb, 32'h1010_0000, 8'd63);
    chk_aw("f1_b1", fb + 1, 32'h1010_0200, 8'd35);
    chk("f1_bufidx", 64'(frame_buf_idx), 64'd1);
    aw_delay = 0;
    w_toggle = 0;

    // frame 2: SLVERR on its second burst
    fb = aw_addr_q.size();
    s_limit = 300;
    wait_done("f2");
    chk_aw("f2_b0", fb, 32'h1020_0000, 8'd63);
    chk("f2_bufidx", 64'(frame_buf_idx), 64'd2);
    chk("f2_wr_error", 64'(wr_error), 64'd1);
    chk("f2_len_error", 64'(len_error), 64'd0);
    repeat (5) @(negedge clk_100Mhz);
    chk("wr_error_held", 64'(wr_error), 64'd1);
    err_clr = 1'b1;
    @(negedge clk_100Mhz);
    err_clr = 1'b0;
    chk("wr_error_clr", 64'(wr_error), 64'd0);

    // frame 3: early tlast on beat 50, wraps ring to buffer 0
    lerr_idx = 350;
    fb = aw_addr_q.size();
    s_limit = 400;
    wait_done("f3");
    chk_aw("f3_b0", fb, 32'h1000_0000, 8'd63);
    chk_aw("f3_b1", fb + 1, 32'h1000_0200, 8'd35);
    chk("f3_bufidx", 64'(frame_buf_idx), 64'd0);
    chk("f3_len_error", 64'(len_error), 64'd1);
    chk("f3_wr_error", 64'(wr_error), 64'd0);

    // frame 4: reset in the middle of the first burst
    s_limit = 500;
    n = 0;
    while (!(in_data && wbeat >= 20) && n < 4000) begin
      @(negedge clk_100Mhz);
      n++;
    end
    chk("pre_rst_wvalid", 64'(WVALID), 64'd1);
    chk("pre_rst_awaddr", 64'(AWADDR), 64'h1010_0000);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wvalid", 64'(WVALID), 64'd0);
    chk("mid_rst_awvalid", 64'(AWVALID), 64'd0);
    chk("mid_rst_wlast", 64'(WLAST), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_awaddr", 64'(AWADDR), 64'd0);
    chk("mid_rst_len_error", 64'(len_error), 64'd0);
    chk("mid_rst_done", 64'(frame_done), 64'd0);
    repeat (3) @(posedge clk_100Mhz);
    s_limit = s_idx;
    @(negedge clk_100Mhz);
    #2;
    s_origin = s_idx;
    exp_w    = s_idx;
    fb       = aw_addr_q.size();
    s_limit  = s_idx + 100;
    rst      = 1'b0;
    wait_done("f5");
    chk_aw("f5_b0", fb, 32'h1000_0000, 8'd63);
    chk_aw("f5_b1", fb + 1, 32'h1000_0200, 8'd35);
    chk("f5_bufidx", 64'(frame_buf_idx), 64'd0);
    chk("f5_len_error", 64'(len_error), 64'd0);

    chk("aw_stable", 64'(stab_viol), 64'd0);
    chk("wvalid_hold", 64'(wv_viol), 64'd0);
    chk("aw_w_excl", 64'(excl_viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/axi4_frame_writer.md
Name: axi4_frame_writer

Overview:
- Parametrised stream-to-memory-mapped frame writer. Accepts a pixel-beat stream in the clk_100Mhz domain, buffers it in an internal FIFO, and writes each frame to DDR as AXI4 INCR bursts through the PS HP port.
- Generalises the single-buffer, fixed 64-beat writer with configurable data width, burst length and frame size, a partial final burst, an N-buffer ring, and BRESP error reporting.
- Sits between the pixel mixer/CDC stage and the PS DDR port; the HDMI reader consumes the completed buffers.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI and stream data width; power of two, 32..128.
- BURST_LEN, 64, maximum beats per burst, 1..256; BURST_LEN*DATA_W/8 <= 4096.
- FRAME_BEATS, 19200, beats per frame (320x240x16b/64b).
- NUM_BUFS, 3, frame buffers in the ring, 1..4.
- FIFO_DEPTH, 512, internal FIFO entries; power of two, >= 2*BURST_LEN.

Ports:
- clk_100Mhz  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_tdata  in  DATA_W  pixel beat.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  beat accepted when s_tvalid & s_tready.
- s_tlast  in  1  last beat of frame; checked only, not used for framing.
- cfg_base_addr  in  ADDR_W  base address of buffer 0; aligned to BURST_LEN*DATA_W/8.
- cfg_stride  in  ADDR_W  byte distance between buffers; same alignment as cfg_base_addr.
- cfg_enable  in  1  run enable.
- err_clr  in  1  clears the sticky error flags.
- AWADDR/AWVALID/AWREADY/AWLEN[7:0]/AWSIZE[2:0]/AWBURST[1:0]/AWCACHE[3:0]/AWPROT[2:0]  AXI4 write address channel.
- WDATA[DATA_W]/WSTRB[DATA_W/8]/WLAST/WVALID/WREADY  AXI4 write data channel.
- BRESP[1:0]/BVALID/BREADY  AXI4 write response channel.
- frame_done  out  1  one-cycle pulse when a frame is fully acknowledged.
- frame_buf_idx  out  2  index of the last completed buffer.
- wr_error  out  1  sticky: a BRESP other than OKAY was received.
- len_error  out  1  sticky: s_tlast position did not match FRAME_BEATS.
- busy  out  1  high when the state machine is not in IDLE.

Behaviour:
- Reset values:
  - AWVALID, WVALID, WLAST, frame_done, wr_error, len_error, busy = 0.
  - AWADDR = 0, frame_buf_idx = 0, write buffer index = 0, frame beat count = 0.
  - FIFO flushed.
- Constant outputs: AWSIZE = log2(DATA_W/8), AWBURST = INCR, AWCACHE = 4'b0011, AWPROT = 0, WSTRB = all ones, BREADY = 1.
- s_tready = cfg_enable_eff & ~fifo_full.
  - cfg_enable_eff samples cfg_enable only at frame boundaries, i.e. when the input beat count is 0.
- Input beat counter:
  - Counts accepted beats and wraps at FRAME_BEATS.
  - If s_tlast=1 when the count is not FRAME_BEATS-1, or s_tlast=0 when it is, set len_error.
  - The data is still written as counted.
- State machine: IDLE, ADDR, DATA, RESP. One burst is outstanding at a time.
- cur_len = min(BURST_LEN, FRAME_BEATS - frame_beat_cnt); this produces the partial final burst.
- IDLE -> ADDR when fifo_count >= cur_len.
  - On that edge: AWADDR <= buf_base + frame_beat_cnt*DATA_W/8, AWLEN <= cur_len-1, AWVALID <= 1.
  - buf_base = cfg_base_addr + idx*cfg_stride, latched when frame_beat_cnt = 0.
- ADDR:
  - AWVALID stays high until AWREADY; the address fields stay stable while waiting.
  - On the handshake: AWVALID <= 0, go to DATA.
- DATA:
  - WVALID = 1 and WDATA = FIFO head (FWFT).
  - Pop on WVALID & WREADY.
  - WLAST = 1 on beat cur_len-1.
  - After the last handshake: WVALID <= 0, go to RESP.
  - WVALID never drops mid-burst; the FIFO already holds cur_len beats.
- RESP:
  - On BVALID: if BRESP != 0, set wr_error.
  - frame_beat_cnt += cur_len.
  - If it reaches FRAME_BEATS:
    - pulse frame_done for one cycle;
    - frame_buf_idx <= idx;
    - idx <= (idx == NUM_BUFS-1) ? 0 : idx+1;
    - frame_beat_cnt <= 0.
  - Go to IDLE.
  - An error does not abort the frame.
- Precedence:
  - err_clr wins over a same-cycle error set.
  - AWVALID and WVALID are never high in the same cycle.
- Reset mid-burst: all channels drop to their reset values immediately. The interconnect is reset by the same rst.
- FIFO full: s_tready = 0, no data loss, upstream stalls.

Optional Feature:
- Macro: AXIW_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bursts[31:0] (count of B handshakes) and perf_stall[31:0] (cycles with s_tvalid & ~s_tready).
  - Both counters saturate and are cleared by err_clr or rst.
- Undefined: the ports and logic are absent.

Decomposition:
- Package axi4_writer_pkg:
  - state encoding constants (IDLE=0, ADDR=1, DATA=2, RESP=3);
  - AXI constants (BURST_INCR, RESP_OKAY, CACHE_BUFFERABLE).
- One sub-module, axiw_sync_fifo: single-clock FWFT FIFO with a count output, parametrised by DATA_W and FIFO_DEPTH.

Test Plan:
- FRAME_BEATS=100, BURST_LEN=64, base=0x1000_0000, continuous input -> two bursts: AWADDR 0x1000_0000/AWLEN 63 then 0x1000_0200/AWLEN 35; WLAST on beats 64 and 100; frame_done after the second B; frame_buf_idx=0.
- NUM_BUFS=3, stride=0x0010_0000, four frames -> first AWADDR of each frame is 0x1000_0000, 0x1010_0000, 0x1020_0000, 0x1000_0000.
- AWREADY held low 10 cycles, WREADY toggling every other cycle -> AWADDR/AWLEN stable; 64 beats in order, no duplicates or drops; WVALID stays high during the burst.
- BRESP=2'b10 on the second burst -> wr_error=1 and held; the frame still completes; err_clr clears it.
- s_tlast on beat 50 of 100 -> len_error=1; address sequence unchanged.
- rst asserted in DATA at beat 20 -> all outputs return to reset values in the same cycle; after release, the next frame starts at buffer 0, offset 0.
